ex_stage: RTL and testbench



---
 rtl/ex_stage_if.sv | 38 +++
 rtl/ex_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID/EX operand and control fields consumed by the
// execute stage together with the results it hands to EX/MEM.
// master = ID/EX side (drives operands), slave = execute stage.
interface ex_stage_if;
  logic [31:0] Read_Data_1_EX;
  logic [31:0] Read_Data_2_EX;
  logic [31:0] signExtended_EX;
  logic [31:0] PC_sumado_EX;
  logic [31:0] instruction_EX;
  logic        RegDest_EX;
  logic        ALUSrc_EX;
  logic        BranchEQ_EX;
  logic        BranchNE_EX;
  logic        ALUOp1_EX;
  logic        ALUOp2_EX;
  logic [31:0] ALU_Result_EX;
  logic        Zero_EX;
  logic [31:0] Branch_Target_EX;
  logic        Branch_Taken_EX;
  logic [4:0]  Write_Reg_EX;
  logic        Stall_EX;

  modport master (
    output Read_Data_1_EX, Read_Data_2_EX, signExtended_EX, PC_sumado_EX,
           instruction_EX, RegDest_EX, ALUSrc_EX, BranchEQ_EX, BranchNE_EX,
           ALUOp1_EX, ALUOp2_EX,
    input  ALU_Result_EX, Zero_EX, Branch_Target_EX, Branch_Taken_EX,
           Write_Reg_EX, Stall_EX
  );

  modport slave (
    input  Read_Data_1_EX, Read_Data_2_EX, signExtended_EX, PC_sumado_EX,
           instruction_EX, RegDest_EX, ALUSrc_EX, BranchEQ_EX, BranchNE_EX,
           ALUOp1_EX, ALUOp2_EX,
    output ALU_Result_EX, Zero_EX, Branch_Target_EX, Branch_Taken_EX,
           Write_Reg_EX, Stall_EX
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Combinational ALU, branch target/decision and
// destination-register select. When the macro EX_MULDIV_EN is defined, an
// iterative 32-step multiply/divide unit with HI/LO registers is built and
// stalls the front of the pipeline while it runs; otherwise mult/div are
// no-ops, mfhi/mflo read 0 and the stall output is tied low.
module ex_stage (
  input  logic      clk,
  input  logic      rst_n,
  ex_stage_if.slave bus
);

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         shamt;
  logic [1:0]         alu_op;
  logic signed [31:0] op_a;
  logic signed [31:0] op_b;
  logic signed [31:0] rt_val;
  logic [31:0]        zimm;
  logic [31:0]        alu_res;
  logic [31:0]        hi_rd;
  logic [31:0]        lo_rd;
  logic               stall;

  assign opcode = bus.instruction_EX[31:26];
  assign funct  = bus.instruction_EX[5:0];
  assign shamt  = bus.instruction_EX[10:6];
  assign alu_op = {bus.ALUOp1_EX, bus.ALUOp2_EX};
  assign op_a   = bus.Read_Data_1_EX;
  assign rt_val = bus.Read_Data_2_EX;
  assign op_b   = bus.ALUSrc_EX ? bus.signExtended_EX : bus.Read_Data_2_EX;
  assign zimm   = {16'h0000, bus.instruction_EX[15:0]};

  // ALU operation select from ALUOp, funct and opcode
  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b10: begin
        case (funct)
          6'h20, 6'h21: alu_res = op_a + op_b;
          6'h22, 6'h23: alu_res = op_a - op_b;
          6'h24:        alu_res = op_a & op_b;
          6'h25:        alu_res = op_a | op_b;
          6'h26:        alu_res = op_a ^ op_b;
          6'h27:        alu_res = ~(op_a | op_b);
          6'h2A:        alu_res = {31'd0, op_a < op_b};
          6'h2B:        alu_res = {31'd0, $unsigned(op_a) < $unsigned(op_b)};
          6'h00:        alu_res = rt_val << shamt;
          6'h02:        alu_res = $unsigned(rt_val) >> shamt;
          6'h03:        alu_res = rt_val >>> shamt;
          6'h10:        alu_res = hi_rd;
          6'h12:        alu_res = lo_rd;
          default:      alu_res = '0;
        endcase
      end
      default: begin
        case (opcode)
          6'h0C:   alu_res = op_a & zimm;
          6'h0D:   alu_res = op_a | zimm;
          6'h0E:   alu_res = op_a ^ zimm;
          6'h0A:   alu_res = {31'd0, op_a < op_b};
          6'h0B:   alu_res = {31'd0, $unsigned(op_a) < $unsigned(op_b)};
          6'h0F:   alu_res = {bus.instruction_EX[15:0], 16'h0000};
          default: alu_res = op_a + op_b;
        endcase
      end
    endcase
  end

  assign bus.ALU_Result_EX    = alu_res;
  assign bus.Zero_EX          = (alu_res == 32'd0);
  assign bus.Branch_Target_EX = bus.PC_sumado_EX + {bus.signExtended_EX[29:0], 2'b00};
  assign bus.Branch_Taken_EX  = (bus.BranchEQ_EX & bus.Zero_EX) |
                                (bus.BranchNE_EX & ~bus.Zero_EX);
  assign bus.Write_Reg_EX     = bus.RegDest_EX ? bus.instruction_EX[15:11]
                                               : bus.instruction_EX[20:16];
  assign bus.Stall_EX         = stall;

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t   md_state;
  md_state_t   md_state_nxt;
  logic        md_start;
  logic        md_signed;
  logic        md_last;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [4:0]  md_cnt;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] md_b;
  logic        md_div;
  logic        md_neg_q;
  logic        md_neg_r;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [63:0] prod;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Two's-complement negate when the flag is set (sign fix-up of magnitudes)
  function automatic logic [31:0] neg_if32(input logic n, input logic [31:0] v);
    return n ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] neg_if64(input logic n, input logic [63:0] v);
    return n ? (64'd0 - v) : v;
  endfunction

  // mult/div work on magnitudes; funct[0]=0 marks the signed variants
  assign md_signed = ~funct[0];
  assign a_neg     = md_signed & op_a[31];
  assign b_neg     = md_signed & rt_val[31];
  assign a_mag     = neg_if32(a_neg, op_a);
  assign b_mag     = neg_if32(b_neg, rt_val);
  assign md_last   = (md_cnt == 5'd31);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_state <= MD_IDLE;
    else        md_state <= md_state_nxt;
  end

  // Next state, start decode and stall; a start is only seen in IDLE so the
  // still-held mult/div does not relaunch from DONE
  always_comb begin
    md_state_nxt = md_state;
    md_start     = 1'b0;
    stall        = 1'b0;
    case (md_state)
      MD_IDLE: begin
        md_start = (alu_op == 2'b10) && (funct[5:2] == 4'b0110);
        stall    = md_start;
        if (md_start) md_state_nxt = MD_BUSY;
      end
      MD_BUSY: begin
        stall = 1'b1;
        if (md_last) md_state_nxt = MD_DONE;
      end
      MD_DONE: md_state_nxt = MD_IDLE;
      default: md_state_nxt = MD_IDLE;
    endcase
  end

  // One shift-add (mult) or restoring-subtract (div) step over {acc_hi, acc_lo}
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_b} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    if (md_div) begin
      if (div_shift >= {1'b0, md_b}) begin
        step_hi = div_shift[31:0] - md_b;
        step_lo = {acc_lo[30:0], 1'b1};
      end else begin
        step_hi = div_shift[31:0];
        step_lo = {acc_lo[30:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo[31:1]};
    end
  end

  // Final sign fix-up; divide by zero forces LO to all ones
  always_comb begin
    prod   = neg_if64(md_neg_q, {step_hi, step_lo});
    fin_hi = prod[63:32];
    fin_lo = prod[31:0];
    if (md_div) begin
      fin_hi = neg_if32(md_neg_r, step_hi);
      fin_lo = (md_b == 32'd0) ? 32'hFFFF_FFFF : neg_if32(md_neg_q, step_lo);
    end
  end

  // Step counter and HI/LO, written on the edge that completes step 32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (md_start)                   md_cnt <= '0;
      else if (md_state == MD_BUSY)   md_cnt <= md_cnt + 5'd1;
      if (md_state == MD_BUSY && md_last) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end

  // Operand latch and accumulator; reloaded on every start, so no reset
  always_ff @(posedge clk) begin
    if (md_start) begin
      acc_hi   <= '0;
      acc_lo   <= a_mag;
      md_b     <= b_mag;
      md_div   <= funct[1];
      md_neg_q <= a_neg ^ b_neg;
      md_neg_r <= a_neg;
    end else if (md_state == MD_BUSY) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  assign hi_rd = hi_q;
  assign lo_rd = lo_q;

  logic unused_bits;
  assign unused_bits = ^bus.instruction_EX[25:21];
`else
  assign hi_rd = '0;
  assign lo_rd = '0;
  assign stall = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{clk, rst_n, bus.instruction_EX[25:21]};
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed bench for ex_stage against an
// arithmetic reference model; follows EX_MULDIV_EN the same way the design does.
module tb_ex_stage;

`ifdef EX_MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, 5'd1, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // Reference ALU straight from the operation table
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] rt,
                                          input logic [31:0] se, input logic [31:0] ins,
                                          input logic alusrc, input logic [1:0] aluop);
    logic [31:0] b;
    logic [31:0] zi;
    int sh;
    b  = alusrc ? se : rt;
    zi = {16'h0000, ins[15:0]};
    sh = int'(ins[10:6]);
    if (aluop == 2'b00) return a + b;
    if (aluop == 2'b01) return a - b;
    if (aluop == 2'b10) begin
      case (ins[5:0])
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: return (a < b) ? 32'd1 : 32'd0;
        6'h00: return rt << sh;
        6'h02: return rt >> sh;
        6'h03: return $signed(rt) >>> sh;
        6'h10: return m_hi;
        6'h12: return m_lo;
        default: return 32'd0;
      endcase
    end
    case (ins[31:26])
      6'h0C: return a & zi;
      6'h0D: return a | zi;
      6'h0E: return a ^ zi;
      6'h0A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h0B: return (a < b) ? 32'd1 : 32'd0;
      6'h0F: return {ins[15:0], 16'h0000};
      default: return a + b;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] rt, input logic [31:0] se,
                       input logic [31:0] pc, input logic [31:0] ins, input logic regdest,
                       input logic alusrc, input logic beq, input logic bne,
                       input logic [1:0] aluop);
    bus.Read_Data_1_EX  = a;
    bus.Read_Data_2_EX  = rt;
    bus.signExtended_EX = se;
    bus.PC_sumado_EX    = pc;
    bus.instruction_EX  = ins;
    bus.RegDest_EX      = regdest;
    bus.ALUSrc_EX       = alusrc;
    bus.BranchEQ_EX     = beq;
    bus.BranchNE_EX     = bne;
    bus.ALUOp1_EX       = aluop[1];
    bus.ALUOp2_EX       = aluop[0];
  endtask

  // Compare every EX output against the model for the inputs currently driven
  task automatic check_all(input string tag);
    logic [31:0] er;
    logic ez;
    er = ref_alu(bus.Read_Data_1_EX, bus.Read_Data_2_EX, bus.signExtended_EX,
                 bus.instruction_EX, bus.ALUSrc_EX, {bus.ALUOp1_EX, bus.ALUOp2_EX});
    ez = (er == 32'd0);
    chk({tag, ".res"}, bus.ALU_Result_EX, er);
    chk({tag, ".zero"}, 32'(bus.Zero_EX), 32'(ez));
    chk({tag, ".target"}, bus.Branch_Target_EX,
        bus.PC_sumado_EX + (bus.signExtended_EX << 2));
    chk({tag, ".taken"}, 32'(bus.Branch_Taken_EX),
        32'((bus.BranchEQ_EX & ez) | (bus.BranchNE_EX & ~ez)));
    chk({tag, ".wreg"}, 32'(bus.Write_Reg_EX),
        32'(bus.RegDest_EX ? bus.instruction_EX[15:11] : bus.instruction_EX[20:16]));
    chk({tag, ".stall"}, 32'(bus.Stall_EX), 32'd0);
  endtask

  task automatic step_op(input string tag, input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] se, input logic [31:0] pc, input logic [31:0] ins,
                         input logic regdest, input logic alusrc, input logic beq,
                         input logic bne, input logic [1:0] aluop);
    @(posedge clk);
    #1 drive(a, rt, se, pc, ins, regdest, alusrc, beq, bne, aluop);
    @(negedge clk);
    check_all(tag);
  endtask

  // Issue a mult/div, count stalled cycles, then read back HI and LO
  task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (MD_ON) begin
      case (fn)
        6'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h19: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
        6'h1A: begin
          if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
          else begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
        end
        default: begin
          if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
          else begin m_hi = a % b; m_lo = a / b; end
        end
      endcase
    end
    @(posedge clk);
    #1 drive(a, b, 32'd0, 32'd0, mk_r(5'd3, 5'd4, 5'd0, fn), 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    @(negedge clk);
    chk("md.res", bus.ALU_Result_EX, 32'd0);
    n = 0;
    while (bus.Stall_EX === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("md.stall_cycles", n, MD_ON ? 32'd33 : 32'd0);
    step_op("mfhi", 32'd0, 32'd0, 32'd0, 32'd0, mk_r(5'd0, 5'd8, 5'd0, 6'h10),
            1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    step_op("mflo", 32'd0, 32'd0, 32'd0, 32'd0, mk_r(5'd0, 5'd9, 5'd0, 6'h12),
            1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
  endtask

  logic [5:0] rfun [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h3F};
  logic [5:0] rop [8]   = '{6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h08, 6'h23};

  initial begin
    logic [31:0] a, rt, ins, pc;
    logic [15:0] imm;
    logic [1:0]  aluop;
    logic [5:0]  fn;

    rst_n = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    chk("rst.res", bus.ALU_Result_EX, 32'd0);
    chk("rst.zero", 32'(bus.Zero_EX), 32'd1);
    chk("rst.taken", 32'(bus.Branch_Taken_EX), 32'd0);
    chk("rst.target", bus.Branch_Target_EX, 32'd0);
    chk("rst.wreg", 32'(bus.Write_Reg_EX), 32'd0);
    chk("rst.stall", 32'(bus.Stall_EX), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    step_op("slt", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd4, mk_r(5'd2, 5'd3, 5'd0, 6'h2A),
            1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    chk("slt.const", bus.ALU_Result_EX, 32'd1);
    step_op("sltu", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd4, mk_r(5'd2, 5'd3, 5'd0, 6'h2B),
            1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    chk("sltu.const", bus.ALU_Result_EX, 32'd0);
    step_op("beq", 32'd5, 32'd5, 32'hFFFF_FFFE, 32'h100, mk_i(6'h04, 5'd2, 16'hFFFE),
            1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
    chk("beq.taken", 32'(bus.Branch_Taken_EX), 32'd1);
    chk("beq.target", bus.Branch_Target_EX, 32'h0000_00F8);
    step_op("lui", 32'h5555_AAAA, 32'd0, 32'h0000_1234, 32'd0, mk_i(6'h0F, 5'd9, 16'h1234),
            1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
    chk("lui.const", bus.ALU_Result_EX, 32'h1234_0000);
    chk("lui.wreg", 32'(bus.Write_Reg_EX), 32'd9);

    run_md(6'h18, 32'hFFFF_FFFD, 32'd7);
    run_md(6'h1A, 32'hFFFF_FFF9, 32'd2);
    run_md(6'h1B, 32'd9, 32'd0);
    run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);

    // Randomized ALU / branch traffic
    for (int i = 0; i < 80; i++) begin
      a     = $urandom;
      rt    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm   = 16'($urandom);
      pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      aluop = 2'($urandom_range(0, 3));
      if (aluop == 2'b10) begin
        fn = rfun[$urandom_range(0, 15)];
        ins = mk_r(5'($urandom), 5'($urandom), 5'($urandom), fn);
        imm = ins[15:0];
      end else if (aluop == 2'b11) begin
        ins = mk_i(rop[$urandom_range(0, 7)], 5'($urandom), imm);
      end else begin
        ins = mk_i(6'h04, 5'($urandom), imm);
      end
      step_op("rand", a, rt, {{16{ins[15]}}, ins[15:0]}, pc, ins,
              1'($urandom), (aluop == 2'b10) ? 1'b0 : 1'($urandom),
              1'($urandom), 1'($urandom), aluop);
    end

    // Randomized mult/div
    for (int i = 0; i < 8; i++) begin
      fn = 6'h18 + 6'($urandom_range(0, 3));
      a  = $urandom_range(0, 1) ? $urandom : (32'($urandom_range(0, 200)) - 32'd100);
      rt = $urandom_range(0, 1) ? $urandom : (32'($urandom_range(0, 20)) - 32'd10);
      if (fn[1] && $urandom_range(0, 3) == 0) rt = 32'd0;
      run_md(fn, a, rt);
    end

    // Asynchronous reset in BUSY cycle 10 of a divu
    @(posedge clk);
    #1 drive(32'd100, 32'd3, 32'd0, 32'd0, mk_r(5'd3, 5'd4, 5'd0, 6'h1B),
             1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    @(negedge clk);
    chk("rstbusy.stall_pre", 32'(bus.Stall_EX), 32'(MD_ON));
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rstbusy.stall", 32'(bus.Stall_EX), 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, mk_r(5'd0, 5'd8, 5'd0, 6'h10),
          1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all("rstbusy.mfhi");
    step_op("rstbusy.mflo", 32'd0, 32'd0, 32'd0, 32'd0, mk_r(5'd0, 5'd9, 5'd0, 6'h12),
            1'b1, 1'b0, 1'b0, 1'b0, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
